// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer for the 8-bit core.
// Owns the PC, fetches over a req/ack handshake, decodes the opcode, starts
// the ALU and waits for its result, then commits the next PC.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   level; leaves IDLE when sampled high
//   stall                   freezes the sequencer while high
//   imem_req/imem_addr      fetch request and address (address == pc)
//   imem_ack/imem_rdata     fetch response, data valid in the ack cycle
//   instr                   latched current instruction
//   ex_start                one-cycle ALU start pulse
//   alu_valid/alu_flag      ALU completion and flag (4'd1 = branch taken)
//   wb_en                   one-cycle register-file write enable
//   pc, halted, retired     current PC, HALT indicator, committed count
module pc_sequencer #(
   parameter int              PC_W     = 8,
   parameter int              INST_W   = 16,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] instr,
   output logic              ex_start,
   input  logic              alu_valid,
   input  logic [3:0]        alu_flag,
   output logic              wb_en,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic [15:0]       retired
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, UPDATE, HALT
   } state_t;

   localparam logic [3:0] OP_HALT   = 4'b0000;
   localparam logic [3:0] OP_JUMP   = 4'b0101;
   localparam logic [3:0] OP_BRANCH = 4'b0110;

   state_t          state;
   logic [3:0]      flag;
   logic [3:0]      op_code;
   logic [PC_W-1:0] pc_next;

   assign op_code   = instr[15:12];
   // pc is itself a register, so the fetch address is registered too
   assign imem_addr = pc;

   always_comb begin
      pc_next = pc + PC_W'(1);
      if (op_code == OP_JUMP)
         pc_next = PC_W'(instr[7:0]);
      else if (op_code == OP_BRANCH && flag == 4'd1)
         pc_next = pc + PC_W'(instr[3:0]) + PC_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         instr    <= '0;
         retired  <= '0;
         flag     <= '0;
         imem_req <= 1'b0;
         ex_start <= 1'b0;
         wb_en    <= 1'b0;
         halted   <= 1'b0;
      end else if (stall) begin
         // everything holds; pulses are cut so they never stretch
         ex_start <= 1'b0;
         wb_en    <= 1'b0;
      end else begin
         ex_start <= 1'b0;
         wb_en    <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state    <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH: if (imem_req && imem_ack) begin
               instr    <= imem_rdata;
               imem_req <= 1'b0;
               state    <= DECODE;
            end
            DECODE: begin
               if (op_code == OP_HALT) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else if (op_code == OP_JUMP) begin
                  state <= UPDATE;
               end else begin
                  state    <= EXEC;
                  ex_start <= 1'b1;
               end
            end
            EXEC: if (alu_valid) begin
               // wb_en is raised on entry so it is high during UPDATE
               flag  <= alu_flag;
               wb_en <= (op_code != OP_BRANCH);
               state <= UPDATE;
            end
            UPDATE: begin
               pc       <= pc_next;
               retired  <= retired + 16'd1;
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            HALT: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
